// File: rtl/ysyx_220066_lsu_if.sv
// Bus interfaces of the ysyx_220066 load/store unit.
//   ysyx_220066_lsu_core_if : core data-memory port (core = master, LSU = slave)
//     req_valid/req_ready/req_wr/req_op/req_addr/req_wdata : request handshake
//     resp_valid/resp_rdata/resp_err                       : one-cycle response
//   ysyx_220066_lsu_mem_if  : 64-bit memory bus (LSU = master, memory = slave)
//     mem_req_valid/ready/wr/addr/wdata/wstrb              : request beat
//     mem_resp_valid/rdata/err                             : response pulse

interface ysyx_220066_lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface ysyx_220066_lsu_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wr;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_220066_lsu.sv
// Load/store unit: takes one core load/store at a time, checks alignment,
// issues an 8-byte-aligned strobed bus beat, waits for the response and
// returns lane-extracted, sign/zero-extended load data. Every bus
// transaction is bounded by a TIMEOUT-cycle watchdog (0 disables it).
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   core : core request/response port (slave side)
//   mem  : 64-bit memory bus (master side)

module ysyx_220066_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_220066_lsu_core_if.slave        core,
    ysyx_220066_lsu_mem_if.master        mem
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            wr_q;
    logic [2:0]      op_q;
    logic [2:0]      off_q;

    logic            bad_c;
    logic [7:0]      wstrb_c;
    logic [63:0]     wdata_c;
    logic [63:0]     lane_c;
    logic [63:0]     load_c;
    logic            timeout_c;

    // Request decode: legality check and lane placement of store data.
    always_comb begin
        bad_c   = 1'b0;
        wstrb_c = 8'h00;
        case (core.req_op[1:0])
            2'd0: wstrb_c = 8'h01;
            2'd1: begin wstrb_c = 8'h03; bad_c = core.req_addr[0];      end
            2'd2: begin wstrb_c = 8'h0F; bad_c = |core.req_addr[1:0];   end
            default: begin wstrb_c = 8'hFF; bad_c = |core.req_addr[2:0]; end
        endcase
        if (core.req_op == 3'b111 || (core.req_wr && core.req_op[2]))
            bad_c = 1'b1;
        wstrb_c = core.req_wr ? (wstrb_c << core.req_addr[2:0]) : 8'h00;
        wdata_c = core.req_wdata << {core.req_addr[2:0], 3'b000};
    end

    // Load extraction from the returned beat using the latched op/offset.
    always_comb begin
        lane_c = mem.mem_resp_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  load_c = {{56{lane_c[7]}},  lane_c[7:0]};
            3'b001:  load_c = {{48{lane_c[15]}}, lane_c[15:0]};
            3'b010:  load_c = {{32{lane_c[31]}}, lane_c[31:0]};
            3'b100:  load_c = {56'd0, lane_c[7:0]};
            3'b101:  load_c = {48'd0, lane_c[15:0]};
            3'b110:  load_c = {32'd0, lane_c[31:0]};
            default: load_c = lane_c;
        endcase
        timeout_c = (TIMEOUT != 0) && (timer == TLAST);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            timer              <= '0;
            wr_q               <= 1'b0;
            op_q               <= 3'd0;
            off_q              <= 3'd0;
            core.req_ready     <= 1'b1;
            core.resp_valid    <= 1'b0;
            core.resp_rdata    <= 64'd0;
            core.resp_err      <= 1'b0;
            mem.mem_req_valid  <= 1'b0;
            mem.mem_req_wr     <= 1'b0;
            mem.mem_req_addr   <= 64'd0;
            mem.mem_req_wdata  <= 64'd0;
            mem.mem_req_wstrb  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        wr_q           <= core.req_wr;
                        op_q           <= core.req_op;
                        off_q          <= core.req_addr[2:0];
                        timer          <= '0;
                        core.req_ready <= 1'b0;
                        if (bad_c) begin
                            state           <= RESP;
                            core.resp_valid <= 1'b1;
                            core.resp_err   <= 1'b1;
                            core.resp_rdata <= 64'd0;
                        end else begin
                            state             <= REQ;
                            mem.mem_req_valid <= 1'b1;
                            mem.mem_req_wr    <= core.req_wr;
                            mem.mem_req_addr  <= {core.req_addr[63:3], 3'b000};
                            mem.mem_req_wdata <= wdata_c;
                            mem.mem_req_wstrb <= wstrb_c;
                        end
                    end
                end
                REQ: begin
                    timer <= timer + TW'(1);
                    if (timeout_c) begin
                        state             <= RESP;
                        mem.mem_req_valid <= 1'b0;
                        core.resp_valid   <= 1'b1;
                        core.resp_err     <= 1'b1;
                        core.resp_rdata   <= 64'd0;
                    end else if (mem.mem_req_ready) begin
                        state             <= WAIT;
                        mem.mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A response in the final allowed cycle wins over the watchdog.
                    if (mem.mem_resp_valid) begin
                        state           <= RESP;
                        core.resp_valid <= 1'b1;
                        core.resp_err   <= mem.mem_resp_err;
                        core.resp_rdata <= (mem.mem_resp_err || wr_q) ? 64'd0 : load_c;
                    end else if (timeout_c) begin
                        state           <= RESP;
                        core.resp_valid <= 1'b1;
                        core.resp_err   <= 1'b1;
                        core.resp_rdata <= 64'd0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    core.resp_valid <= 1'b0;
                    core.req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
module tb_ysyx_220066_lsu;

    localparam int unsigned TO = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ysyx_220066_lsu_core_if c_if ();
    ysyx_220066_lsu_mem_if  m_if ();

    ysyx_220066_lsu #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (c_if.slave),
        .mem  (m_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model, straight from the access rules.
    function automatic int m_size(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic bit m_bad(input bit wr, input logic [2:0] op, input logic [63:0] a);
        int s = m_size(op);
        return (op == 3'b111) || (wr && op[2]) || ((a % 64'(s)) != 0);
    endfunction

    function automatic logic [7:0] m_strb(input bit wr, input logic [2:0] op, input logic [63:0] a);
        logic [7:0] r = 8'h00;
        int off = int'(a % 64'd8);
        for (int i = 0; i < 8; i++)
            if (wr && i >= off && i < off + m_size(op)) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] beat);
        int s = m_size(op);
        int off = int'(a % 64'd8);
        logic [63:0] v = 64'd0;
        logic [7:0] b;
        for (int i = 0; i < s; i++) begin
            b = beat[8*(off+i) +: 8];
            v = v + (64'(b) << (8*i));
        end
        if (!op[2] && s < 8 && v[8*s-1])
            v = v + ~((64'd1 << (8*s)) - 64'd1);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One core access; hold = cycles the bus keeps ready low, lat = cycles
    // between acceptance and response. Junk responses are thrown at REQ.
    task automatic do_access(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                             input logic [63:0] wdata, input int hold, input int lat,
                             input logic [63:0] beat, input bit berr);
        bit bad = m_bad(wr, op, addr);
        check("req_ready_idle", c_if.req_ready, 1);
        c_if.req_valid = 1'b1;
        c_if.req_wr    = wr;
        c_if.req_op    = op;
        c_if.req_addr  = addr;
        c_if.req_wdata = wdata;
        step();
        c_if.req_valid = 1'b0;
        c_if.req_addr  = {$urandom, $urandom};
        c_if.req_wdata = {$urandom, $urandom};
        c_if.req_op    = 3'($urandom);
        c_if.req_wr    = 1'($urandom);
        check("req_ready_busy", c_if.req_ready, 0);
        if (bad) begin
            check("bad_resp_valid", c_if.resp_valid, 1);
            check("bad_resp_err", c_if.resp_err, 1);
            check("bad_resp_rdata", c_if.resp_rdata, 0);
            check("bad_no_bus", m_if.mem_req_valid, 0);
            step();
            check("bad_resp_drop", c_if.resp_valid, 0);
            check("bad_ready_back", c_if.req_ready, 1);
            check("bad_no_bus2", m_if.mem_req_valid, 0);
            return;
        end
        for (int k = 0; k <= hold; k++) begin
            check("req_valid", m_if.mem_req_valid, 1);
            check("req_addr", m_if.mem_req_addr, addr & ~64'h7);
            check("req_wr", m_if.mem_req_wr, wr);
            check("req_wstrb", m_if.mem_req_wstrb, m_strb(wr, op, addr));
            if (wr) check("req_wdata", m_if.mem_req_wdata, wdata << (8 * (addr % 64'd8)));
            check("no_resp_req", c_if.resp_valid, 0);
            m_if.mem_req_ready  = (k == hold);
            m_if.mem_resp_valid = 1'($urandom);
            m_if.mem_resp_rdata = {$urandom, $urandom};
            m_if.mem_resp_err   = 1'($urandom);
            step();
        end
        m_if.mem_req_ready  = 1'b0;
        m_if.mem_resp_valid = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            check("wait_req_low", m_if.mem_req_valid, 0);
            check("no_resp_wait", c_if.resp_valid, 0);
            if (k == lat) begin
                m_if.mem_resp_valid = 1'b1;
                m_if.mem_resp_rdata = beat;
                m_if.mem_resp_err   = berr;
            end
            step();
        end
        m_if.mem_resp_valid = 1'b0;
        m_if.mem_resp_rdata = {$urandom, $urandom};
        check("resp_valid", c_if.resp_valid, 1);
        check("resp_err", c_if.resp_err, berr);
        check("resp_rdata", c_if.resp_rdata, (wr || berr) ? 64'd0 : m_load(op, addr, beat));
        check("resp_ready_low", c_if.req_ready, 0);
        step();
        check("resp_pulse", c_if.resp_valid, 0);
        check("ready_after", c_if.req_ready, 1);
    endtask

    // Load that the bus never answers; acc_at < 0 means the bus never accepts.
    task automatic do_timeout(input int acc_at);
        check("to_ready_idle", c_if.req_ready, 1);
        c_if.req_valid = 1'b1;
        c_if.req_wr    = 1'b0;
        c_if.req_op    = 3'b011;
        c_if.req_addr  = 64'h2008;
        step();
        c_if.req_valid = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            check("to_no_resp", c_if.resp_valid, 0);
            check("to_req_valid", m_if.mem_req_valid, (acc_at < 0 || k <= acc_at) ? 1 : 0);
            if (acc_at < 0 || k <= acc_at)
                check("to_req_addr", m_if.mem_req_addr, 64'h2008);
            m_if.mem_req_ready  = (k == acc_at);
            m_if.mem_resp_valid = (k == acc_at);
            m_if.mem_resp_rdata = 64'h1111_2222_3333_4444;
            m_if.mem_resp_err   = 1'b0;
            step();
        end
        m_if.mem_req_ready  = 1'b0;
        m_if.mem_resp_valid = 1'b0;
        check("to_resp_valid", c_if.resp_valid, 1);
        check("to_resp_err", c_if.resp_err, 1);
        check("to_resp_rdata", c_if.resp_rdata, 0);
        check("to_req_drop", m_if.mem_req_valid, 0);
        step();
        check("to_ready_back", c_if.req_ready, 1);
        check("to_pulse", c_if.resp_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, c_if.req_ready, 1);
        check({tag, "_resp_valid"}, c_if.resp_valid, 0);
        check({tag, "_resp_rdata"}, c_if.resp_rdata, 0);
        check({tag, "_resp_err"}, c_if.resp_err, 0);
        check({tag, "_mem_valid"}, m_if.mem_req_valid, 0);
        check({tag, "_mem_wr"}, m_if.mem_req_wr, 0);
        check({tag, "_mem_addr"}, m_if.mem_req_addr, 0);
        check({tag, "_mem_wdata"}, m_if.mem_req_wdata, 0);
        check({tag, "_mem_wstrb"}, m_if.mem_req_wstrb, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [63:0] addr;
        bit          wr;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        c_if.req_valid = 1'b0; c_if.req_wr = 1'b0; c_if.req_op = 3'd0;
        c_if.req_addr = 64'd0; c_if.req_wdata = 64'd0;
        m_if.mem_req_ready = 1'b0; m_if.mem_resp_valid = 1'b0;
        m_if.mem_resp_rdata = 64'd0; m_if.mem_resp_err = 1'b0;
        #12;
        check_reset_outputs("rst");
        rst = 1'b1;
        step();

        // Directed cases.
        do_access(1'b0, 3'b000, 64'h8000_0007, 64'd0, 0, 0, 64'h8000_0000_0000_0000, 1'b0);
        do_access(1'b0, 3'b100, 64'h8000_0007, 64'd0, 0, 0, 64'h8000_0000_0000_0000, 1'b0);
        do_access(1'b1, 3'b001, 64'h1002, 64'h1234, 0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0);
        do_access(1'b0, 3'b010, 64'h1002, 64'd0, 0, 0, 64'd0, 1'b0);
        do_access(1'b1, 3'b101, 64'h1000, 64'h55, 0, 0, 64'd0, 1'b0);
        do_access(1'b0, 3'b011, 64'h4000, 64'd0, 2, 1, 64'hFEDC_BA98_7654_3210, 1'b0);
        do_access(1'b0, 3'b110, 64'h4004, 64'd0, 1, 2, 64'h8765_4321_0000_0000, 1'b1);
        do_timeout(5);
        do_timeout(-1);

        // Reset while waiting for the bus response.
        c_if.req_valid = 1'b1; c_if.req_wr = 1'b1; c_if.req_op = 3'b011;
        c_if.req_addr = 64'h3000; c_if.req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        step();
        c_if.req_valid = 1'b0;
        m_if.mem_req_ready = 1'b1;
        step();
        m_if.mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        #2 rst = 1'b1;
        step();
        m_if.mem_resp_valid = 1'b1;
        m_if.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        m_if.mem_resp_valid = 1'b0;
        check("stray_resp", c_if.resp_valid, 0);
        step();
        check_reset_outputs("stray");

        // Randomized accesses.
        for (int n = 0; n < 80; n++) begin
            wr   = 1'($urandom);
            op   = 3'($urandom);
            addr = {$urandom, $urandom};
            if ($urandom_range(3) != 0)
                addr = addr & ~(64'(m_size(op)) - 64'd1);
            do_access(wr, op, addr, {$urandom, $urandom}, int'($urandom_range(2)),
                      int'($urandom_range(2)), {$urandom, $urandom}, ($urandom_range(7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_lsu.md
# ysyx_220066_lsu

Load/store unit between the ysyx_220066 core's data-memory port and a 64-bit handshaked memory bus. Takes one load or store request at a time from the core, checks alignment, builds an 8-byte-aligned bus beat with byte strobes, waits for the bus response, then returns lane-extracted, sign/zero-extended load data. The core stalls while `req_ready` is low. A cycle timeout bounds every bus transaction.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_wr  in  1  1 = store, 0 = load
- req_op  in  3  MemOp: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse; core always accepts
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal op, bus error or timeout
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_wr  out  1  store beat
- mem_req_addr  out  64  {req_addr[63:3], 3'b000}
- mem_req_wdata  out  64  store data shifted to lane
- mem_req_wstrb  out  8  byte strobes; 0 for loads
- mem_resp_valid  in  1  bus response pulse
- mem_resp_rdata  in  64  aligned 8-byte beat
- mem_resp_err  in  1  bus error

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch wr/op/addr/wdata and clear the timer. If the request is bad, go to RESP with err. Bad means: op 111; store with op[2]=1; h with addr[0]≠0; w/wu with addr[1:0]≠0; d with addr[2:0]≠0. Otherwise go to REQ.
- REQ: `mem_req_valid`=1. All mem_req_* fields hold stable until `mem_req_ready`, then go to WAIT. A `mem_resp_valid` in REQ is ignored.
- WAIT: on `mem_resp_valid`, register the data and err, then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Timer: increments each cycle in REQ or WAIT. When it reaches TIMEOUT (TIMEOUT≠0), go to RESP with err=1 and drop `mem_req_valid`. The bus contract forbids responses after TIMEOUT cycles. Any `mem_resp_valid` in IDLE or RESP is discarded.
- Store lanes: size s = 1/2/4/8 bytes from op[1:0]. `wdata` = `req_wdata` << (8*addr[2:0]). `wstrb` = ((1<<s)-1) << addr[2:0].
- Load extraction: lane = `mem_resp_rdata` >> (8*addr[2:0]), truncated to s bytes. Sign-extend when op[2]=0, zero-extend when op[2]=1. d returns the beat unchanged.
- On error, `resp_rdata`=0.

## Timing
- Reset (async, `rst`=0): state IDLE, timer 0. Outputs: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_req_valid`=0, `mem_req_wr`=0, `mem_req_addr`=0, `mem_req_wdata`=0, `mem_req_wstrb`=0. Reset mid-transaction abandons it with no response.
- Good access, accepted cycle N: `mem_req_valid` at N+1. If `mem_req_ready` and `mem_resp_valid` arrive at the earliest points, `resp_valid` is at N+3. Minimum occupancy is 4 cycles per access.
- Bad request accepted at N: `resp_valid`+`resp_err` at N+1 with no bus activity. The next request is accepted at N+2.
- `req_ready` is low from N+1 until the cycle after `resp_valid`.
- mem_req_* are registered. resp_* are registered and change only on entry to RESP.
- Timeout: first entering REQ at cycle M gives `resp_err` at cycle M+TIMEOUT.

## Test plan
- Load lb at addr 0x80000007, bus beat 0x80_00000000000000 -> `mem_req_addr` 0x80000000, `wstrb` 0x00, `resp_rdata` 0xFFFFFFFFFFFFFF80. Repeat with lbu -> 0x0000000000000080.
- Store sh at addr 0x1002, wdata 0x1234 -> `wstrb` 0x0C, `mem_req_wdata`[31:16]=0x1234, `resp_err`=0, `resp_rdata`=0.
- Misaligned lw at 0x1002 and illegal store op 101 -> `resp_err`=1 one cycle after acceptance, `mem_req_valid` never asserted.
- `mem_req_ready` held low 5 cycles, then `mem_resp_valid` in the same cycle as `mem_req_ready` -> request fields stable throughout; early response ignored; timeout fires at M+TIMEOUT.
- TIMEOUT=8, bus never responds -> `resp_err`=1 eight cycles after REQ entry, `mem_req_valid` drops, and the next request is accepted.
- `rst` asserted while in WAIT -> all outputs at reset values immediately, no `resp_valid`; a stray later `mem_resp_valid` is discarded.
